// File: rtl/sprite_life_pkg.sv
// Shared types, palette and glyph ROMs for the HUD lives bar.
package sprite_life_pkg;

   typedef enum logic [1:0] {
      ST_ALIVE  = 2'd0,
      ST_INVULN = 2'd1,
      ST_DEAD   = 2'd2
   } life_state_e;

   // Palette indices and their colours
   localparam logic [1:0]  PAL_CLEAR = 2'd0;
   localparam logic [1:0]  PAL_BLACK = 2'd1;
   localparam logic [1:0]  PAL_RED   = 2'd2;
   localparam logic [23:0] RGB_BLACK = 24'h000000;
   localparam logic [23:0] RGB_RED   = 24'hF05650;

   // Glyph geometry in glyph pixels
   localparam int GLYPH_H     = 9;
   localparam int LIFE_W      = 20;
   localparam int HEART_W     = 9;
   localparam int RETRY_W     = 31;
   localparam int RETRY_SHIFT = 4;

   // "LIFE" label, red on transparent; column 0 is the MSB of each row
   localparam logic [19:0] LIFE_ROM [GLYPH_H] = '{
      20'b0000_0_000_0_0000_0_0000_00,
      20'b1000_0_111_0_1111_0_1111_00,
      20'b1000_0_010_0_1000_0_1000_00,
      20'b1000_0_010_0_1000_0_1000_00,
      20'b1000_0_010_0_1110_0_1110_00,
      20'b1000_0_010_0_1000_0_1000_00,
      20'b1000_0_010_0_1000_0_1000_00,
      20'b1111_0_111_0_1000_0_1111_00,
      20'b0000_0_000_0_0000_0_0000_00
   };

   // Empty heart: black outline only
   localparam logic [8:0] HEART_EMPTY [GLYPH_H] = '{
      9'b011000110,
      9'b100101001,
      9'b100010001,
      9'b100000001,
      9'b100000001,
      9'b010000010,
      9'b001000100,
      9'b000101000,
      9'b000010000
   };

   // Filled heart: red interior drawn inside the empty-heart outline
   localparam logic [8:0] HEART_FILLED [GLYPH_H] = '{
      9'b000000000,
      9'b011000110,
      9'b011101110,
      9'b011111110,
      9'b011111110,
      9'b001111100,
      9'b000111000,
      9'b000010000,
      9'b000000000
   };

   // "RETRY" banner, black on transparent
   localparam logic [30:0] RETRY_ROM [GLYPH_H] = '{
      31'b0_0000_0_0000_0_00000_0_0000_0_00000_0000,
      31'b0_1110_0_1111_0_11111_0_1110_0_10001_0000,
      31'b0_1001_0_1000_0_00100_0_1001_0_10001_0000,
      31'b0_1001_0_1000_0_00100_0_1001_0_01010_0000,
      31'b0_1110_0_1110_0_00100_0_1110_0_00100_0000,
      31'b0_1010_0_1000_0_00100_0_1010_0_00100_0000,
      31'b0_1001_0_1000_0_00100_0_1001_0_00100_0000,
      31'b0_1001_0_1111_0_00100_0_1001_0_00100_0000,
      31'b0_0000_0_0000_0_00000_0_0000_0_00000_0000
   };

   function automatic logic [1:0] life_pix(input logic [3:0] row, input logic [4:0] col);
      logic [1:0] pix;
      pix = PAL_CLEAR;
      if (row < 4'(GLYPH_H) && col < 5'(LIFE_W) && LIFE_ROM[row][5'(LIFE_W - 1) - col])
         pix = PAL_RED;
      return pix;
   endfunction

   function automatic logic [1:0] heart_pix(input logic [3:0] row, input logic [3:0] col,
                                            input logic filled);
      logic [1:0] pix;
      pix = PAL_CLEAR;
      if (row < 4'(GLYPH_H) && col < 4'(HEART_W)) begin
         if (HEART_EMPTY[row][4'(HEART_W - 1) - col])
            pix = PAL_BLACK;
         else if (filled && HEART_FILLED[row][4'(HEART_W - 1) - col])
            pix = PAL_RED;
      end
      return pix;
   endfunction

   function automatic logic [1:0] retry_pix(input logic [3:0] row, input logic [4:0] col);
      logic [1:0] pix;
      pix = PAL_CLEAR;
      if (row < 4'(GLYPH_H) && col < 5'(RETRY_W) && RETRY_ROM[row][5'(RETRY_W - 1) - col])
         pix = PAL_BLACK;
      return pix;
   endfunction

endpackage

// File: rtl/life_state_fsm.sv
// Life state machine: input edge detection, ALIVE/INVULN/DEAD FSM,
// lives count, invulnerability countdown and free-running frame counter.
module life_state_fsm
   import sprite_life_pkg::*;
#(
   parameter int MAX_LIVES     = 3,
   parameter int INVULN_FRAMES = 60,
   parameter int BLINK_FRAMES  = 8,
   localparam int LIVES_W      = $clog2(MAX_LIVES + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               v_sync,
   input  logic               crushed,
   input  logic               heal,
   input  logic               restart,
   output life_state_e        state,
   output logic [LIVES_W-1:0] lives,
   output logic               blink,
   output logic               is_dead,
   output logic               invuln
);

   localparam int                 BLINK_BIT = $clog2(BLINK_FRAMES);
   localparam logic [LIVES_W-1:0] FULL      = LIVES_W'(MAX_LIVES);
   localparam logic [LIVES_W-1:0] ONE_LIFE  = LIVES_W'(1);
   localparam logic [7:0]         INV_LOAD  = 8'(INVULN_FRAMES);

   // Raw inputs packed as {restart, heal, crushed, v_sync}
   logic [3:0] raw_in, prev_q, ev_q;
   logic       vsync_ev, crush_ev, heal_ev, restart_ev;

   life_state_e        state_q, state_nxt;
   logic [LIVES_W-1:0] lives_q, lives_nxt;
   logic [7:0]         inv_q, inv_nxt;
   logic [7:0]         frame_q, frame_nxt;

   assign raw_in     = {restart, heal, crushed, v_sync};
   assign vsync_ev   = ev_q[0];
   assign crush_ev   = ev_q[1];
   assign heal_ev    = ev_q[2];
   assign restart_ev = ev_q[3];

   // Rising-edge detectors; events are registered so they act one clock later
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q <= '0;
         ev_q   <= '0;
      end else begin
         prev_q <= raw_in;
         ev_q   <= raw_in & ~prev_q;
      end
   end

   // State, lives and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ALIVE;
         lives_q <= FULL;
         inv_q   <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_nxt;
         lives_q <= lives_nxt;
         inv_q   <= inv_nxt;
         frame_q <= frame_nxt;
      end
   end

   // Next state with priority restart > crush > heal; a crush that lands
   // suppresses both heal and the countdown tick of the same cycle
   always_comb begin
      state_nxt = state_q;
      lives_nxt = lives_q;
      inv_nxt   = inv_q;
      frame_nxt = frame_q + 8'(vsync_ev);
      if (restart_ev) begin
         state_nxt = ST_ALIVE;
         lives_nxt = FULL;
         inv_nxt   = '0;
      end else if (crush_ev && state_q == ST_ALIVE) begin
         if (lives_q <= ONE_LIFE) begin
            state_nxt = ST_DEAD;
            lives_nxt = '0;
            inv_nxt   = '0;
         end else begin
            state_nxt = ST_INVULN;
            lives_nxt = lives_q - ONE_LIFE;
            inv_nxt   = INV_LOAD;
         end
      end else begin
         if (heal_ev && state_q != ST_DEAD && lives_q < FULL)
            lives_nxt = lives_q + ONE_LIFE;
         if (state_q == ST_INVULN && vsync_ev) begin
            if (inv_q <= 8'd1) begin
               inv_nxt   = '0;
               state_nxt = ST_ALIVE;
            end else begin
               inv_nxt = inv_q - 8'd1;
            end
         end
      end
   end

   // Decoded outputs
   always_comb begin
      state   = state_q;
      lives   = lives_q;
      blink   = frame_q[BLINK_BIT];
      is_dead = (state_q == ST_DEAD);
      invuln  = (state_q == ST_INVULN);
   end

endmodule

// File: rtl/sprite_life_bar.sv
// HUD lives bar: "LIFE" label plus MAX_LIVES hearts, and a RETRY banner
// while dead. Pixel path is purely combinational from i_x/i_y and state.
module sprite_life_bar
   import sprite_life_pkg::*;
#(
   parameter int MAX_LIVES     = 3,
   parameter int SCALE_SHIFT   = 2,
   parameter int POS_X         = 360,
   parameter int POS_Y         = 10,
   parameter int RETRY_X       = 400,
   parameter int RETRY_Y       = 280,
   parameter int INVULN_FRAMES = 60,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic [15:0]                        i_x,
   input  logic [15:0]                        i_y,
   input  logic                               i_v_sync,
   input  logic                               i_crushed,
   input  logic                               i_heal,
   input  logic                               i_restart,
   output logic [7:0]                         o_red,
   output logic [7:0]                         o_green,
   output logic [7:0]                         o_blue,
   output logic                               o_sprite_hit,
   output logic [$clog2(MAX_LIVES+1)-1:0]     o_lives,
   output logic                               o_is_dead,
   output logic                               o_invuln
);

   localparam int LIVES_W  = $clog2(MAX_LIVES + 1);
   localparam int BAR_COLS = LIFE_W + HEART_W * MAX_LIVES;

   life_state_e        state;
   logic [LIVES_W-1:0] lives;
   logic               blink;

   logic [15:0] bar_dx, bar_dy, gx, gy, hc;
   logic [15:0] ret_dx, ret_dy, rx, ry;
   logic        in_bar, in_banner;
   logic [3:0]  heart_idx, heart_col;
   logic        heart_filled;
   logic [1:0]  bar_pix, pal;

   life_state_fsm #(
      .MAX_LIVES     (MAX_LIVES),
      .INVULN_FRAMES (INVULN_FRAMES),
      .BLINK_FRAMES  (BLINK_FRAMES)
   ) u_fsm (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .v_sync  (i_v_sync),
      .crushed (i_crushed),
      .heal    (i_heal),
      .restart (i_restart),
      .state   (state),
      .lives   (lives),
      .blink   (blink),
      .is_dead (o_is_dead),
      .invuln  (o_invuln)
   );

   assign o_lives = lives;

   // Glyph coordinates; left/above the box wraps to a huge offset and falls outside
   always_comb begin
      bar_dx    = i_x - 16'(POS_X);
      bar_dy    = i_y - 16'(POS_Y);
      gx        = bar_dx >> SCALE_SHIFT;
      gy        = bar_dy >> SCALE_SHIFT;
      in_bar    = (gx < 16'(BAR_COLS)) && (gy < 16'(GLYPH_H));
      ret_dx    = i_x - 16'(RETRY_X);
      ret_dy    = i_y - 16'(RETRY_Y);
      rx        = ret_dx >> RETRY_SHIFT;
      ry        = ret_dy >> RETRY_SHIFT;
      in_banner = (rx < 16'(RETRY_W)) && (ry < 16'(GLYPH_H)) && (state == ST_DEAD);
   end

   // Heart index and column by comparing against each 9-column slot, no divider
   always_comb begin
      hc        = gx - 16'(LIFE_W);
      heart_idx = '0;
      heart_col = '0;
      for (int k = 0; k < MAX_LIVES; k++) begin
         if (hc >= 16'(HEART_W * k) && hc < 16'(HEART_W * (k + 1))) begin
            heart_idx = 4'(k);
            heart_col = 4'(hc - 16'(HEART_W * k));
         end
      end
   end

   // Heart fill: lives held, plus the just-lost heart blinking while invulnerable
   always_comb begin
      heart_filled = (heart_idx < 4'(lives)) ||
                     ((state == ST_INVULN) && (heart_idx == 4'(lives)) && blink);
   end

   // Palette index; an opaque bar pixel wins over the banner
   always_comb begin
      if (gx < 16'(LIFE_W))
         bar_pix = life_pix(gy[3:0], gx[4:0]);
      else
         bar_pix = heart_pix(gy[3:0], heart_col, heart_filled);
      pal = PAL_CLEAR;
      if (in_bar && bar_pix != PAL_CLEAR)
         pal = bar_pix;
      else if (in_banner)
         pal = retry_pix(ry[3:0], rx[4:0]);
   end

   // Palette to colour
   always_comb begin
      {o_red, o_green, o_blue} = 24'h000000;
      o_sprite_hit = (pal != PAL_CLEAR);
      case (pal)
         PAL_BLACK: {o_red, o_green, o_blue} = RGB_BLACK;
         PAL_RED:   {o_red, o_green, o_blue} = RGB_RED;
         default:   {o_red, o_green, o_blue} = 24'h000000;
      endcase
   end

endmodule
